// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-bus controller: frame geometry,
// peripheral register map and controller state encoding.
package spi_pkg;

  localparam int FRAME_W     = 16;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int MAX_ADDRESS = 4;

  localparam logic [ADDR_W-1:0] REG_OUT   = 7'h00;
  localparam logic [ADDR_W-1:0] REG_BIDIR = 7'h01;
  localparam logic [ADDR_W-1:0] REG_PWM0  = 7'h02;
  localparam logic [ADDR_W-1:0] REG_PWM1  = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM2  = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  typedef logic [FRAME_W-1:0] frame_t;

  function automatic frame_t build_frame(input logic wr,
                                         input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] wdata);
    return {wr, addr, wdata};
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Host request/response signals plus the four-wire SPI bus of one controller.
interface spi_controller_if;
  import spi_pkg::*;

  logic              start;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              nCS;
  logic              SCLK;
  logic              COPI;
  logic              CIPO;

  // master: the SPI controller; slave: the host and peripheral around it
  modport master (
    input  start, wr, addr, wdata, CIPO,
    output busy, done, rdata, nCS, SCLK, COPI
  );

  modport slave (
    output start, wr, addr, wdata, CIPO,
    input  busy, done, rdata, nCS, SCLK, COPI
  );

endinterface

// File: rtl/spi_phase_timer.sv
// Phase timer: counts 0..CLK_DIV-1 while run_i is high and flags the last
// cycle of each phase with tc_o; held at 0 while idle.
module spi_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  output logic [7:0] phase_o,
  output logic       tc_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_o = cnt_q;
  assign tc_o    = run_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_controller.sv
// Mode-0 SPI controller sending one 16-bit {wr, addr, wdata} frame per start,
// MSB first, capturing the peripheral's last 8 bits into rdata.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_controller_if.master bus
);
  import spi_pkg::*;

  localparam logic [7:0] DONE_PHASE = 8'(CLK_DIV - 2);

  spi_state_e        state_q;
  logic              ncs_q;
  logic              sclk_q;
  logic              copi_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  frame_t            tx_q;
  frame_t            rx_q;
  frame_t            rx_d;
  frame_t            frame_d;
  logic [3:0]        bit_cnt_q;

  logic [7:0] phase;
  logic       tc;
  logic       run;
  logic       accept;
  logic       done_d;

  spi_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run),
    .phase_o (phase),
    .tc_o    (tc)
  );

  assign run     = (state_q != ST_IDLE);
  assign frame_d = build_frame(bus.wr, bus.addr, bus.wdata);
  assign rx_d    = {rx_q[FRAME_W-2:0], bus.CIPO};

  // done is raised one cycle early so it coincides with the final GAP cycle,
  // which lets a start in the done cycle chain frames with a CLK_DIV gap.
  assign done_d = (state_q == ST_GAP) && (phase == DONE_PHASE);
  assign accept = bus.start && !busy_q &&
                  ((state_q == ST_IDLE) || ((state_q == ST_GAP) && tc));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ncs_q     <= 1'b1;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      done_q <= done_d;
      if (done_d) begin
        busy_q  <= 1'b0;
        rdata_q <= rx_q[DATA_W-1:0];
      end

      if (accept) begin
        state_q   <= ST_SETUP;
        ncs_q     <= 1'b0;
        copi_q    <= frame_d[FRAME_W-1];
        tx_q      <= {frame_d[FRAME_W-2:0], 1'b0};
        rx_q      <= '0;
        busy_q    <= 1'b1;
        bit_cnt_q <= '0;
      end else if (tc) begin
        unique case (state_q)
          ST_SETUP, ST_LOW: begin
            sclk_q  <= 1'b1;
            state_q <= ST_HIGH;
          end
          ST_HIGH: begin
            sclk_q <= 1'b0;
            rx_q   <= rx_d;
            if (bit_cnt_q == 4'd15) begin
              state_q <= ST_HOLD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              copi_q    <= tx_q[FRAME_W-1];
              tx_q      <= {tx_q[FRAME_W-2:0], 1'b0};
              state_q   <= ST_LOW;
            end
          end
          ST_HOLD: begin
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            state_q <= ST_GAP;
          end
          ST_GAP: begin
            bit_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.nCS   = ncs_q;
  assign bus.SCLK  = sclk_q;
  assign bus.COPI  = copi_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: vector table of frames against a looped-back
// register peripheral, plus abort, ignored-start and back-to-back sequences.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int NV      = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_controller_if bus ();

  spi_controller #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Looped-back peripheral: shifts COPI on SCLK rise, answers reg[addr] on
  // the last 8 bits, commits a write only after a complete 16-bit frame.
  logic [7:0]  p_regs [0:MAX_ADDRESS] = '{8'h00, 8'h00, 8'h5A, 8'h00, 8'h00};
  logic [15:0] p_sh        = '0;
  int          p_cnt       = 0;
  logic [7:0]  p_dout      = '0;
  logic        p_cipo      = 1'b0;
  logic        p_ncs_prev  = 1'b1;
  logic        p_sclk_prev = 1'b0;

  assign bus.CIPO = p_cipo;

  always @(bus.SCLK or bus.nCS) begin
    if (bus.nCS === 1'b1 && p_ncs_prev === 1'b0) begin
      if (p_cnt == 16 && p_sh[15] && p_sh[14:8] <= 7'(MAX_ADDRESS))
        p_regs[p_sh[14:8]] = p_sh[7:0];
      p_cipo = 1'b0;
    end
    if (bus.nCS === 1'b0 && p_ncs_prev === 1'b1) begin
      p_cnt  = 0;
      p_cipo = 1'b0;
    end
    if (bus.nCS === 1'b0 && bus.SCLK === 1'b1 && p_sclk_prev === 1'b0) begin
      p_sh = {p_sh[14:0], bus.COPI};
      p_cnt++;
    end
    if (bus.nCS === 1'b0 && bus.SCLK === 1'b0 && p_sclk_prev === 1'b1) begin
      if (p_cnt == 8)
        p_dout = (p_sh[6:0] <= 7'(MAX_ADDRESS)) ? p_regs[p_sh[6:0]] : 8'h00;
      if (p_cnt >= 8 && p_cnt < 16)
        p_cipo = p_dout[15 - p_cnt];
    end
    p_ncs_prev  = bus.nCS;
    p_sclk_prev = bus.SCLK;
  end

  typedef struct packed {
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  typedef struct packed {
    logic        wr;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] frame;
    logic [7:0]  rdata;
    logic [7:0]  reg0;
    logic [7:0]  reg1;
    logic [7:0]  reg2;
  } vec_t;

  exp_t exp_q [$];
  vec_t vt [NV];

  int n_cmp = 0;
  int n_err = 0;

  bit          s_ncs    = 1'b1;
  bit          s_sclk   = 1'b0;
  int          rises    = 0;
  int          low_run  = 0;
  int          high_run = 0;
  int          last_low = 0;
  int          gap_len  = 0;
  int          done_cnt = 0;
  logic [15:0] copi_cap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: sample at the falling edge, track nCS/SCLK activity, and
  // score each done pulse against the oldest expected frame.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.nCS === 1'b0) begin
      if (s_ncs) begin
        gap_len  = high_run;
        rises    = 0;
        copi_cap = '0;
        low_run  = 0;
      end
      low_run++;
      high_run = 0;
    end else begin
      if (!s_ncs) last_low = low_run;
      high_run++;
    end
    s_ncs = (bus.nCS !== 1'b0);
    if (bus.SCLK === 1'b1 && !s_sclk) begin
      rises++;
      copi_cap = {copi_cap[14:0], bus.COPI};
    end
    s_sclk = (bus.SCLK === 1'b1);
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with rdata 0x%0h, expected no done", bus.rdata);
      end else begin
        e = exp_q.pop_front();
        check("rdata", bus.rdata, e.rdata);
        check("copi_frame", copi_cap, e.frame);
        check("sclk_rises", rises, 16);
        check("ncs_low_cycles", last_low, 33 * CLK_DIV);
      end
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, 32'(done_cnt != d0), 1);
  endtask

  task automatic wait_rises(input string name, input int target, input int budget);
    int n = 0;
    while (rises != target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_rises_reached"}, rises, target);
  endtask

  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d,
                      input logic [15:0] f, input logic [7:0] r, input bit push);
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.start = 1'b1;
    if (push) exp_q.push_back('{frame: f, rdata: r});
    tick();
    bus.start = 1'b0;
    bus.wr    = 1'($urandom);
    bus.addr  = 7'($urandom);
    bus.wdata = 8'($urandom);
    check("busy_after_start", bus.busy, 1);
  endtask

  initial begin
    int d0;

    //          wr    addr   wdata  frame     rdata  reg0   reg1   reg2
    vt[0] = '{1'b1, 7'h00, 8'hA5, 16'h80A5, 8'h00, 8'hA5, 8'h00, 8'h5A};
    vt[1] = '{1'b1, 7'h01, 8'h3C, 16'h813C, 8'h00, 8'hA5, 8'h3C, 8'h5A};
    vt[2] = '{1'b0, 7'h02, 8'hFF, 16'h02FF, 8'h5A, 8'hA5, 8'h3C, 8'h5A};
    vt[3] = '{1'b0, 7'h00, 8'h00, 16'h0000, 8'hA5, 8'hA5, 8'h3C, 8'h5A};
    vt[4] = '{1'b1, 7'h01, 8'h81, 16'h8181, 8'h3C, 8'hA5, 8'h81, 8'h5A};
    vt[5] = '{1'b0, 7'h7F, 8'h00, 16'h7F00, 8'h00, 8'hA5, 8'h81, 8'h5A};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) tick();
    check("rst_ncs", bus.nCS, 1);
    check("rst_sclk", bus.SCLK, 0);
    check("rst_copi", bus.COPI, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < NV; i++) begin
      d0 = done_cnt;
      send(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].frame, vt[i].rdata, 1'b1);
      wait_done("vec", 400);
      repeat (8) tick();
      check("vec_done_count", done_cnt - d0, 1);
      check("vec_busy_idle", bus.busy, 0);
      check("vec_reg0", p_regs[0], vt[i].reg0);
      check("vec_reg1", p_regs[1], vt[i].reg1);
      check("vec_reg2", p_regs[2], vt[i].reg2);
    end

    // start pulsed during bit 5 must not disturb the frame in flight
    d0 = done_cnt;
    send(1'b1, 7'h00, 8'h11, 16'h8011, 8'hA5, 1'b1);
    wait_rises("ignored", 6, 200);
    bus.start = 1'b1;
    bus.wr    = 1'b1;
    bus.addr  = 7'h01;
    bus.wdata = 8'hEE;
    tick();
    bus.start = 1'b0;
    wait_done("ignored", 400);
    repeat (200) tick();
    check("ignored_done_count", done_cnt - d0, 1);
    check("ignored_reg0", p_regs[0], 8'h11);
    check("ignored_reg1", p_regs[1], 8'h81);

    // start held through done chains a second frame after a CLK_DIV gap
    d0 = done_cnt;
    bus.wr    = 1'b1;
    bus.addr  = 7'h01;
    bus.wdata = 8'h55;
    bus.start = 1'b1;
    exp_q.push_back('{frame: 16'h8155, rdata: 8'h81});
    tick();
    check("b2b_busy", bus.busy, 1);
    bus.addr  = 7'h00;
    bus.wdata = 8'h66;
    exp_q.push_back('{frame: 16'h8066, rdata: 8'h11});
    wait_done("b2b_first", 400);
    tick();
    bus.start = 1'b0;
    check("b2b_gap", gap_len, CLK_DIV);
    check("b2b_second_busy", bus.busy, 1);
    wait_done("b2b_second", 400);
    repeat (8) tick();
    check("b2b_done_count", done_cnt - d0, 2);
    check("b2b_reg0", p_regs[0], 8'h66);
    check("b2b_reg1", p_regs[1], 8'h55);

    // reset in the high phase of bit 7 aborts without done or register write
    d0 = done_cnt;
    send(1'b1, 7'h00, 8'h99, 16'h8099, 8'h00, 1'b0);
    wait_rises("abort", 8, 200);
    check("abort_sclk_high", bus.SCLK, 1);
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    check("abort_ncs", bus.nCS, 1);
    check("abort_sclk", bus.SCLK, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (200) tick();
    check("abort_done_count", done_cnt - d0, 0);
    check("abort_rdata", bus.rdata, 0);
    check("abort_reg0", p_regs[0], 8'h66);
    check("abort_reg1", p_regs[1], 8'h55);

    // a read after the abort still works
    send(1'b0, 7'h02, 8'h00, 16'h0200, 8'h5A, 1'b1);
    wait_done("recover", 400);
    repeat (8) tick();
    check("recover_rdata_hold", bus.rdata, 8'h5A);
    check("recover_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
